// File: rtl/rr_arbiter_4to1.sv
// rr_arbiter_4to1: round-robin arbiter / sequencer sharing one valid/ready
// output channel between four requesters via a 4-to-1 data mux.
//
// Optional feature macro: ARB_BURST_EN
//   undefined (default): every transferred beat ends the grant, in_last is
//                        ignored and out_last is tied high.
//   defined:             the grant is held until a beat with in_last[sel]=1
//                        transfers; out_last follows in_last[sel] while busy.
//
// Handshake: a beat transfers in any cycle where out_valid && out_ready are
// both high; out_valid is only raised while a requester is granted and still
// requesting, and ack pulses for the granted requester in exactly that cycle.
//
// The debug output `busy` mirrors the FSM state (1 = BUSY, 0 = IDLE).
module rr_arbiter_4to1 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_last,
    output logic [3:0]         grant,
    output logic [1:0]         sel,
    output logic [3:0]         ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] last;
    logic [1:0] winner;
    logic       any_req;
    logic       active;
    logic       xfer;
    logic       beat_end;

    // Round-robin search: first set req bit starting just after `last`.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = last + 2'd1;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

    // A beat may only be offered while granted and not being reset, so a
    // reset landing mid-beat can never produce a transfer or an ack.
    assign active    = (state == BUSY) && !rst;
    assign out_valid = active && req[sel];
    assign xfer      = out_valid && out_ready;
    assign out_data  = in_data[sel*WIDTH +: WIDTH];
    assign busy      = (state == BUSY);

    // One-hot completion pulse for the granted requester on its transfer.
    always_comb begin
        ack = '0;
        if (xfer) begin
            ack = 4'b0001 << sel;
        end
    end

`ifdef ARB_BURST_EN
    assign beat_end = in_last[sel];
    assign out_last = active ? in_last[sel] : 1'b0;
`else
    logic unused_in_last;
    assign unused_in_last = ^in_last;
    assign beat_end       = 1'b1;
    assign out_last       = 1'b1;
`endif

    // Arbitration FSM: grant/sel/last are registered, updated on state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 2'd3;
            sel   <= 2'd0;
            grant <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel   <= winner;
                        last  <= winner;
                        grant <= 4'b0001 << winner;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req[sel]) begin
                        // Abort: requester withdrew; `last` keeps its index.
                        grant <= 4'b0000;
                        state <= IDLE;
                    end else if (xfer && beat_end) begin
                        grant <= 4'b0000;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= 4'b0000;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4to1.sv
// tb_rr_arbiter_4to1: self-checking bench for rr_arbiter_4to1 with an
// expected-transfer queue popped whenever the DUT acks a beat.
module tb_rr_arbiter_4to1;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_last;
    logic [3:0]     grant;
    logic [1:0]     sel;
    logic [3:0]     ack;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           busy;

    rr_arbiter_4to1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .in_last   (in_last),
        .grant     (grant),
        .sel       (sel),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    // ---------------- scoreboard state ----------------
    logic [W+1:0] exp_q[$];   // {requester index, data}
    int           n_checks = 0;
    int           n_errors = 0;
    logic [3:0]   rel;        // requesters to release after this cycle
    bit           sticky;     // requesters re-request immediately after ack

`ifdef ARB_BURST_EN
    localparam logic EXP_IDLE_LAST = 1'b0;
`else
    localparam logic EXP_IDLE_LAST = 1'b1;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample on the falling edge; pop the scoreboard on every ack.
    task automatic sample_edge();
        logic [W+1:0] e;
        @(negedge clk);
        rel = '0;
        if (ack != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {28'd0, ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_ack", {28'd0, ack}, {28'd0, 4'b0001 << e[W+1:W]});
                check("sb_data", {24'd0, out_data}, {24'd0, e[W-1:0]});
            end
            if (out_last) rel = ack;
        end
    endtask

    // Move just past the rising edge; acked requesters drop their request.
    task automatic drive_edge();
        @(posedge clk);
        #1;
        if (!sticky) req = req & ~rel;
        rel = '0;
    endtask

    task automatic cyc();
        sample_edge();
        drive_edge();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] p;
        p = l;
        for (int k = 0; k < 4; k++) begin
            p = p + 2'd1;
            if (r[p]) return p;
        end
        return l;
    endfunction

    function automatic logic [W-1:0] dat(input int i);
        return in_data[i*W +: W];
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] model_last;
        logic [1:0] w;
        bit         got;

        rst       = 1'b1;
        req       = 4'b0000;
        in_last   = 4'b1111;
        out_ready = 1'b0;
        sticky    = 1'b0;
        rel       = '0;
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'($urandom_range(0, 255));
        @(posedge clk); #1;
        do_reset();

        // Reset state.
        sample_edge();
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_sel", {30'd0, sel}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_last", {31'd0, out_last}, {31'd0, EXP_IDLE_LAST});
        check("rst_data", {24'd0, out_data}, {24'd0, dat(0)});
        drive_edge();

        // Single request from requester 2.
        req = 4'b0100;
        in_data[2*W +: W] = 8'hA5;
        out_ready = 1'b1;
        exp_q.push_back({2'd2, 8'hA5});
        sample_edge();
        check("t1_latency_grant", {28'd0, grant}, 32'd0);
        drive_edge();
        sample_edge();
        check("t1_grant", {28'd0, grant}, 32'h4);
        check("t1_sel", {30'd0, sel}, 32'd2);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data", {24'd0, out_data}, 32'hA5);
        check("t1_ack", {28'd0, ack}, 32'h4);
        drive_edge();
        sample_edge();
        check("t1_idle_grant", {28'd0, grant}, 32'd0);
        check("t1_idle_valid", {31'd0, out_valid}, 32'd0);
        drive_edge();

        // All four requesting after reset: order 0,1,2,3,0 with IDLE between.
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = W'(8'h10 + i);
        sticky = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = 2'(k % 4);
            exp_q.push_back({w, dat(int'(w))});
            sample_edge();
            check("t2_idle", {28'd0, grant}, 32'd0);
            drive_edge();
            sample_edge();
            check("t2_order", {28'd0, grant}, {28'd0, 4'b0001 << w});
            drive_edge();
        end
        sticky = 1'b0;
        req = 4'b0000;
        cyc();

        // Backpressure on requester 1 (last grant was 0).
        req = 4'b0010;
        in_data[1*W +: W] = 8'h3C;
        out_ready = 1'b0;
        exp_q.push_back({2'd1, 8'h3C});
        cyc();
        for (int k = 0; k < 5; k++) begin
            sample_edge();
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_data", {24'd0, out_data}, 32'h3C);
            check("t3_hold_ack", {28'd0, ack}, 32'd0);
            check("t3_hold_grant", {28'd0, grant}, 32'h2);
            drive_edge();
        end
        out_ready = 1'b1;
        sample_edge();
        check("t3_ack", {28'd0, ack}, 32'h2);
        drive_edge();
        sample_edge();
        check("t3_idle", {28'd0, grant}, 32'd0);
        drive_edge();

        // Abort: requester 3 wins (last=1), drops before ready; 0 follows.
        req = 4'b1001;
        in_data[0] = 1'b0;
        in_data[0*W +: W] = 8'h5A;
        out_ready = 1'b0;
        cyc();
        sample_edge();
        check("t4_grant3", {28'd0, grant}, 32'h8);
        check("t4_no_ack", {28'd0, ack}, 32'd0);
        drive_edge();
        req = 4'b0001;
        out_ready = 1'b1;
        sample_edge();
        check("t4_abort_valid", {31'd0, out_valid}, 32'd0);
        check("t4_abort_ack", {28'd0, ack}, 32'd0);
        drive_edge();
        sample_edge();
        check("t4_abort_idle", {28'd0, grant}, 32'd0);
        drive_edge();
        exp_q.push_back({2'd0, 8'h5A});
        sample_edge();
        check("t4_next_grant", {28'd0, grant}, 32'h1);
        drive_edge();
        sample_edge();
        check("t4_idle", {28'd0, grant}, 32'd0);
        drive_edge();

        // Random traffic with random backpressure against a round-robin model.
        model_last = 2'd0;
        in_last = 4'b1111;
        for (int it = 0; it < 30; it++) begin
            if (req == 4'b0000) begin
                req = 4'($urandom_range(1, 15));
                for (int i = 0; i < 4; i++) begin
                    if (req[i]) in_data[i*W +: W] = W'($urandom_range(0, 255));
                end
            end
            w = rr_pick(req, model_last);
            model_last = w;
            exp_q.push_back({w, dat(int'(w))});
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                sample_edge();
                if (ack != 4'b0000) got = 1'b1;
                drive_edge();
            end
            check("rand_ack_seen", {31'd0, got}, 32'd1);
        end
        req = 4'b0000;
        cyc();

`ifdef ARB_BURST_EN
        // Burst of 3 beats from requester 0 while requester 1 waits.
        do_reset();
        req = 4'b0011;
        in_last = 4'b0010;
        in_data[0*W +: W] = 8'hD0;
        in_data[1*W +: W] = 8'hE1;
        out_ready = 1'b1;
        sample_edge();
        check("b_idle", {28'd0, grant}, 32'd0);
        drive_edge();
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back({2'd0, W'(8'hD0 + b)});
            sample_edge();
            check("b_grant", {28'd0, grant}, 32'h1);
            check("b_ack", {28'd0, ack}, 32'h1);
            check("b_last", {31'd0, out_last}, {31'd0, (b == 2)});
            drive_edge();
            in_data[0*W +: W] = W'(8'hD0 + b + 1);
            if (b == 1) in_last[0] = 1'b1;
        end
        sample_edge();
        check("b_bubble", {28'd0, grant}, 32'd0);
        drive_edge();
        exp_q.push_back({2'd1, 8'hE1});
        sample_edge();
        check("b_next_grant", {28'd0, grant}, 32'h2);
        drive_edge();
        cyc();
        in_last = 4'b0000;
`endif

        // Reset asserted while a beat is pending on requester 2.
        do_reset();
        req = 4'b0100;
        in_data[2*W +: W] = 8'h77;
        in_data[0*W +: W] = 8'h66;
        out_ready = 1'b0;
        cyc();
        sample_edge();
        check("r_grant", {28'd0, grant}, 32'h4);
        check("r_valid", {31'd0, out_valid}, 32'd1);
        drive_edge();
        rst = 1'b1;
        out_ready = 1'b1;
        sample_edge();
        check("r_no_xfer_ack", {28'd0, ack}, 32'd0);
        drive_edge();
        rst = 1'b0;
        req = 4'b0101;
        in_last = 4'b1111;
        sample_edge();
        check("r_after_grant", {28'd0, grant}, 32'd0);
        check("r_after_valid", {31'd0, out_valid}, 32'd0);
        check("r_after_ack", {28'd0, ack}, 32'd0);
        drive_edge();
        exp_q.push_back({2'd0, 8'h66});
        exp_q.push_back({2'd2, 8'h77});
        sample_edge();
        check("r_prio0", {28'd0, grant}, 32'h1);
        drive_edge();
        cyc();
        sample_edge();
        check("r_then2", {28'd0, grant}, 32'h4);
        drive_edge();
        cyc();

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4to1.md
# rr_arbiter_4to1

Round-robin arbiter and sequencer that shares one output channel between four requesters by driving the select of a 4-to-1 multiplexer. It grants one requester at a time and steers that requester's data onto a single valid/ready output. It reports completion back to the granted requester with a one-cycle ack. It sits between four producer blocks and a single downstream consumer.

## Interface
Parameters:
- WIDTH, 8, data width per requester.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i = requester i.
- in_data  input  4*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- in_last  input  4  last-beat flag per requester; used only with ARB_BURST_EN.
- grant  output  4  one-hot current grant; all zero when idle.
- sel  output  2  mux select of the granted requester.
- ack  output  4  one-hot, high for exactly the cycle in which the granted requester's beat transfers.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  in_data of requester sel.
- out_last  output  1  in_last[sel] with ARB_BURST_EN; constant 1 without it.

## Operation
- Two states: IDLE and BUSY. A 2-bit pointer `last` holds the most recently granted requester.
- IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise, choose the first set req bit, searching from (last+1) mod 4 upward with wrap.
  - Load sel and last with the winner and go to BUSY.
- BUSY:
  - grant = one-hot(sel).
  - out_valid = req[sel].
  - out_data = in_data[sel] (combinational mux).
  - A transfer occurs when out_valid && out_ready. In that cycle, ack[sel] = 1.
- End of grant:
  - Without ARB_BURST_EN, every transfer ends the grant and the state goes to IDLE.
  - With ARB_BURST_EN, only a transfer with in_last[sel] = 1 ends the grant.
- Abort: if req[sel] drops while in BUSY, go to IDLE next cycle. No ack is issued and `last` keeps the aborted index.
- Requester rules:
  - Hold req, in_data and in_last stable from assertion until ack.
  - req may deassert only after ack, or as an abort.
- Simultaneous requests are resolved solely by round-robin order. No requester waits more than 3 grants.
- Reset values:
  - State = IDLE, last = 3 (so requester 0 has first priority), sel = 0.
  - grant = 0, ack = 0, out_valid = 0.
  - out_data follows in_data[0] combinationally.
  - out_last = 0 with ARB_BURST_EN (since out_valid = 0); 1 without.
- Reset asserted mid-burst or mid-beat:
  - Return to IDLE on the next edge, dropping the grant and issuing no ack.
  - The pending beat is not transferred.

## Timing
- Arbitration latency: req sampled high in IDLE at edge N gives grant and out_valid high after edge N (cycle N+1).
- The ack cycle equals the handshake cycle. The grant is removed after the following edge.
- Without ARB_BURST_EN, every beat costs at least 2 cycles (BUSY, IDLE): peak throughput is 1 beat per 2 cycles.
- With ARB_BURST_EN, beats within a burst transfer back-to-back at 1 per cycle. There is one IDLE bubble between bursts.
- out_ready low holds BUSY indefinitely. The output beat stays stable and no timeout is applied.
- grant, sel, state and last are registered. out_valid, out_data, out_last and ack are combinational from registered state and inputs.

## Configuration
- ARB_BURST_EN defined:
  - in_last is honoured.
  - The grant is held across beats until the beat flagged last transfers.
  - out_last = in_last[sel] while BUSY.
- ARB_BURST_EN undefined:
  - in_last is ignored.
  - Each beat is a separate arbitration.
  - out_last is tied to 1.

## Test plan
- Reset then a single request: req=4'b0100, in_data[2]=8'hA5, out_ready=1 -> grant=4'b0100, sel=2, out_data=8'hA5 one cycle after req; ack[2] pulses once; IDLE next cycle.
- All request after reset: req=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0 with one IDLE cycle between each grant.
- Backpressure: granted requester 1, out_ready=0 for 5 cycles -> out_valid=1 and out_data stable for 5 cycles, ack=0; out_ready=1 -> ack[1] in that cycle.
- Abort: requester 3 granted, req[3] dropped before out_ready -> IDLE next cycle, no ack; pending req[0] granted next.
- ARB_BURST_EN: requester 0 sends 3 beats with in_last only on beat 3, requester 1 also requesting, out_ready=1 -> 3 consecutive ack[0] cycles, out_last=1 on the third, then IDLE, then grant=4'b0010.
- Reset mid-burst: rst=1 during beat 2 of a burst -> next cycle grant=0, out_valid=0, ack=0; after release requester 0 has priority.
